store_set_clear_ctrl: RTL
=========================

STORE_SET_CLEAR_CTRL -- requirements
Module: store_set_clear_ctrl

Interface
REQ-001 Parameter SSIT_IDX_W, default 10, SHALL set the SSIT index width; sweep covers 2^SSIT_IDX_W entries.
REQ-002 Parameter INTERVAL_W, default 20, SHALL set the width of interval_in and the internal interval counter.
REQ-003 One clock, clock; reset asynchronous and active-high, reset; no other clock or reset inputs.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high; forces every register and output to its reset value.
REQ-006 enable_in  input  1  enables periodic clearing.
REQ-007 interval_in  input  INTERVAL_W  cycles between periodic clears; 0 disables periodic clears.
REQ-008 force_clear_in  input  1  single-cycle request for an immediate clear.
REQ-009 rename_idle_in  input  1  rename holds no in-flight store-set lookups; a sweep may start.
REQ-010 stall_out  output  1  rename stall request.
REQ-011 ssit_clr_we_out  output  1  SSIT entry clear strobe.
REQ-012 ssit_clr_index_out  output  SSIT_IDX_W  SSIT entry being cleared.
REQ-013 lfst_flush_out  output  1  one-cycle pulse; drives the LFST flush input (all LFST valid bits cleared).
REQ-014 busy_out  output  1  high in every state except IDLE.
REQ-015 done_out  output  1  one-cycle pulse at clear completion.
REQ-016 clear_count_out  output  8  completed clears; saturates at 255.

Function
REQ-017 FSM states SHALL be IDLE, REQ, SWEEP, FLUSH and DONE; registered state; all outputs decoded from registered state/counters only.
REQ-018 IDLE: interval counter SHALL increment each cycle while enable_in=1 and interval_in!=0; hold while enable_in=0; reset to 0 when interval_in=0.
REQ-019 IDLE -> REQ SHALL occur when (enable_in=1, interval_in!=0, counter==interval_in-1) or force_clear_in=1 or pending_force=1; counter cleared to 0 on that transition.
REQ-020 force_clear_in=1 in any non-IDLE state SHALL set pending_force; pending_force cleared on the next IDLE->REQ; multiple requests collapse into one.
REQ-021 REQ: stall_out=1; REQ -> SWEEP on the first cycle rename_idle_in=1 (earliest one cycle after entering REQ); no timeout.
REQ-022 SWEEP: ssit_clr_we_out=1 every cycle; ssit_clr_index_out starts at 0, +1 per cycle; after index 2^SSIT_IDX_W-1 -> FLUSH; sweep lasts exactly 2^SSIT_IDX_W cycles; index then wraps to 0.
REQ-023 FLUSH: lfst_flush_out=1 for exactly one cycle, then -> DONE.
REQ-024 DONE: done_out=1 for one cycle; clear_count_out +1 unless already 255; -> IDLE next cycle.
REQ-025 stall_out SHALL be 1 in REQ, SWEEP and FLUSH and 0 in IDLE and DONE.
REQ-026 ssit_clr_we_out and lfst_flush_out SHALL never be 1 outside SWEEP and FLUSH respectively.
REQ-027 enable_in or interval_in changes outside IDLE SHALL NOT abort a clear in progress.
REQ-028 rename_idle_in SHALL be ignored outside REQ.
REQ-029 Latency from force_clear_in in IDLE with rename_idle_in held 1 to done_out SHALL be 2^SSIT_IDX_W+4 cycles.

Reset
REQ-030 On reset, the block SHALL enter IDLE and hold all outputs at reset values: stall_out, ssit_clr_we_out, lfst_flush_out, busy_out and done_out 0; ssit_clr_index_out 0; clear_count_out 0.
REQ-031 On reset, the interval counter and pending_force SHALL be 0.
REQ-032 Reset mid-sweep SHALL abandon the clear without issuing lfst_flush_out; no partial-clear resume after reset release.

Verification
REQ-033 Force clear: force_clear_in pulse in IDLE, rename_idle_in=1 -> stall_out high next cycle, we_out for indices 0..1023 in order, lfst_flush_out pulse, done_out 1028 cycles after request, clear_count_out=1.
REQ-034 Periodic clear: enable_in=1, interval_in=100 -> REQ entered 100 cycles after reset release; after DONE, the next REQ follows 100 IDLE cycles later.
REQ-035 Rename hold-off: rename_idle_in=0 for 50 cycles in REQ -> stall_out=1, we_out=0 throughout; SWEEP starts the cycle after rename_idle_in rises.
REQ-036 Pending force: force_clear_in during SWEEP -> after DONE, one IDLE cycle, then REQ again; only one extra clear for three pulses.
REQ-037 Reset mid-operation: reset asserted at sweep index 500 -> all outputs 0 immediately (asynchronous), no lfst_flush_out, clear_count_out=0.
REQ-038 Saturation/disable: 256 forced clears -> clear_count_out=255; interval_in=0 with enable_in=1 -> no periodic clear in 10^6 cycles.

Source files
------------

// File: rtl/store_set_clear_ctrl.sv
// store_set_clear_ctrl: periodic/forced SSIT sweep clear followed by an LFST flush
module store_set_clear_ctrl #(
    parameter int SSIT_IDX_W = 10,
    parameter int INTERVAL_W = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_in,
    input  logic [INTERVAL_W-1:0] interval_in,
    input  logic                  force_clear_in,
    input  logic                  rename_idle_in,
    output logic                  stall_out,
    output logic                  ssit_clr_we_out,
    output logic [SSIT_IDX_W-1:0] ssit_clr_index_out,
    output logic                  lfst_flush_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [7:0]            clear_count_out
);
    typedef enum logic [2:0] {IDLE, REQ, SWEEP, FLUSH, DONE} state_e;
    state_e                state_q, state_d;
    logic [INTERVAL_W-1:0] cnt_q, cnt_d;
    logic [SSIT_IDX_W-1:0] idx_q, idx_d;
    logic [7:0]            count_q, count_d;
    logic                  pend_q, pend_d, armed_q, armed_d, fire;

    // Periodic trigger fires on the last counted cycle of the interval
    assign fire = enable_in && interval_in != '0 && cnt_q == interval_in - INTERVAL_W'(1);

    // Next-state logic; REQ waits one cycle (armed) before honouring rename idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        count_d = count_q;
        armed_d = 1'b0;
        pend_d  = pend_q | (force_clear_in && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (fire || force_clear_in || pend_q) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = interval_in == '0 ? '0 : enable_in ? cnt_q + INTERVAL_W'(1) : cnt_q;
                end
            end
            REQ: begin
                armed_d = 1'b1;
                state_d = armed_q && rename_idle_in ? SWEEP : REQ;
            end
            SWEEP: begin
                idx_d   = idx_q + SSIT_IDX_W'(1);
                state_d = idx_q == '1 ? FLUSH : SWEEP;
            end
            FLUSH: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                count_d = count_q == 8'hFF ? count_q : count_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset abandons any clear in progress
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
        end
    end

    assign stall_out          = state_q == REQ || state_q == SWEEP || state_q == FLUSH;
    assign ssit_clr_we_out    = state_q == SWEEP;
    assign ssit_clr_index_out = idx_q;
    assign lfst_flush_out     = state_q == FLUSH;
    assign busy_out           = state_q != IDLE;
    assign done_out           = state_q == DONE;
    assign clear_count_out    = count_q;
endmodule
